// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with press/release debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat key_valid pulses while a key is held.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_SD = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int MAX_P  = (MAX_SD > REPEAT_CYCLES) ? MAX_SD : REPEAT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       rows_meta_q;
    logic [3:0]       rows_s_q;
    logic [CNT_W-1:0] dwell_q;
    logic [CNT_W-1:0] deb_q;
    logic [1:0]       col_q;
    logic [1:0]       cand_row_q;
    logic [3:0]       cols_q;
    logic [3:0]       key_code_q;
    logic             key_valid_q;
    logic             key_held_q;
`ifdef KEYPAD_REPEAT_EN
    logic [CNT_W-1:0] rep_q;
`endif

    logic [1:0] col_d;
    logic [3:0] cols_d;
    logic       press_d;
    logic [1:0] low_row_d;
    logic       cand_ok_d;
    logic       cand_high_d;
    logic       release_done_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    // Lowest-index low row wins when several rows are pulled low together.
    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            default:  return 4'hD;
        endcase
    endfunction

    always_comb begin
        col_d          = col_q + 2'd1;
        cols_d         = ~(4'b0001 << col_d);
        press_d        = ~&rows_s_q;
        low_row_d      = lowest_low(rows_s_q);
        cand_ok_d      = press_d && (low_row_d == cand_row_q);
        cand_high_d    = rows_s_q[cand_row_q];
        release_done_d = cand_high_d && (deb_q == DEB_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows_meta_q <= 4'hF;
            rows_s_q    <= 4'hF;
            state_q     <= SCAN;
            dwell_q     <= '0;
            deb_q       <= '0;
            col_q       <= 2'd0;
            cand_row_q  <= 2'd0;
            cols_q      <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            rows_meta_q <= rows;
            rows_s_q    <= rows_meta_q;
            key_valid_q <= 1'b0;

            case (state_q)
                SCAN: begin
                    if (dwell_q == DWELL_LAST) begin
                        dwell_q <= '0;
                        if (press_d) begin
                            cand_row_q <= low_row_d;
                            deb_q      <= '0;
                            state_q    <= DEBOUNCE;
                        end else begin
                            col_q  <= col_d;
                            cols_q <= cols_d;
                        end
                    end else begin
                        dwell_q <= sat_inc(dwell_q);
                    end
                end

                DEBOUNCE: begin
                    if (!cand_ok_d) begin
                        deb_q   <= '0;
                        dwell_q <= '0;
                        col_q   <= col_d;
                        cols_q  <= cols_d;
                        state_q <= SCAN;
                    end else if (deb_q == DEB_LAST) begin
                        key_code_q  <= key_map(cand_row_q, col_q);
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                        deb_q       <= '0;
                        state_q     <= HOLD;
`ifdef KEYPAD_REPEAT_EN
                        rep_q       <= '0;
`endif
                    end else begin
                        deb_q <= sat_inc(deb_q);
                    end
                end

                HOLD: begin
                    // deb_q counts consecutive release samples of the candidate row.
                    if (release_done_d) begin
                        key_held_q <= 1'b0;
                        deb_q      <= '0;
                        dwell_q    <= '0;
                        col_q      <= col_d;
                        cols_q     <= cols_d;
                        state_q    <= SCAN;
                    end else if (cand_high_d) begin
                        deb_q <= sat_inc(deb_q);
                    end else begin
                        deb_q <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    if (release_done_d) begin
                        rep_q <= '0;
                    end else if (rep_q == REP_LAST) begin
                        rep_q       <= '0;
                        key_valid_q <= 1'b1;
                    end else begin
                        rep_q <= sat_inc(rep_q);
                    end
`endif
                end

                default: begin
                    state_q <= SCAN;
                end
            endcase
        end
    end

    assign cols      = cols_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a physical keypad model drives rows from cols,
// expected codes are queued at press time and popped by a monitor on key_valid.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int REP      = 20;
    localparam int LAT_MIN  = DEB + 3;
    localparam int LAT_MAX  = 2 + 4 * SCAN_DIV + DEB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = '0;
    logic [3:0]  kmap [16];
    logic [3:0]  exp_q [$];
    int          pulse_cyc_q [$];
    int          last_pulse_cyc = -1;
    logic [3:0]  last_code = 4'h0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    keypad_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rows(rows),
        .cols(cols),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key shorts its row to its column: the row reads low only while that column is driven.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_held(input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (key_held !== val && n < budget) begin
            tick(1);
            n++;
        end
        check(name, key_held, val);
    endtask

    // Monitor: every key_valid must match the oldest pending expected code.
    always @(negedge clk) begin
        if (reset) begin
            if (key_valid) begin
                pulse_cyc_q.push_back(cyc);
                last_pulse_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse: key_code=%0h, expected no pulse", key_code);
                end else begin
                    last_code = exp_q.pop_front();
                    check("key_code", key_code, last_code);
                    check("held_with_valid", key_held, 1'b1);
                end
            end else begin
                check("code_stable", key_code, last_code);
            end
        end else begin
            last_code = 4'h0;
        end
    end

    task automatic press_release(input int r, input int c, input int b_lo, input int b_hi,
                                 input int hold);
        int t0;
        if (b_lo > 0) begin
            pressed = '0;
            pressed[r*4+c] = 1'b1;
            tick(b_lo);
            pressed = '0;
            tick(b_hi);
        end
        exp_q.push_back(kmap[r*4+c]);
        pressed = '0;
        pressed[r*4+c] = 1'b1;
        t0 = cyc;
        wait_held(1'b1, LAT_MAX + 4, "press_held");
        check_range("press_latency", last_pulse_cyc - t0, LAT_MIN, LAT_MAX);
        tick(hold);
        pressed = '0;
        tick(DEB + 1);
        check("held_before_release_done", key_held, 1'b1);
        tick(1);
        check("released_after_deb", key_held, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int r, c, t_acc, npulse;
        int got [$];
        kmap = '{4'h1, 4'h2, 4'h3, 4'hA,
                 4'h4, 4'h5, 4'h6, 4'hB,
                 4'h7, 4'h8, 4'h9, 4'hC,
                 4'hE, 4'h0, 4'hF, 4'hD};

        // Reset state and column rotation
        reset = 1'b0;
        tick(3);
        check("rst_cols", cols, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 4'h0);
        check("rst_held", key_held, 1'b0);
        reset = 1'b1;
        tick(3);
        check("scan_col0", cols, 4'b1110);
        tick(1);
        check("scan_col1", cols, 4'b1101);
        tick(4);
        check("scan_col2", cols, 4'b1011);
        tick(4);
        check("scan_col3", cols, 4'b0111);
        tick(4);
        check("scan_wrap", cols, 4'b1110);

        // Clean press of row1/col2 (code 6)
        press_release(1, 2, 0, 0, 3);
        tick(5);

        // Bouncy press of row0/col0 (code 1)
        press_release(0, 0, 5, 1, 2);
        tick(5);

        // Two rows on col3: row0 wins, later key during hold ignored
        exp_q.push_back(4'hA);
        pressed = '0;
        pressed[0*4+3] = 1'b1;
        pressed[1*4+3] = 1'b1;
        wait_held(1'b1, LAT_MAX + 4, "two_row_held");
        pressed[2*4+0] = 1'b1;
        tick(30);
        check("second_key_still_held", key_held, 1'b1);
        check("second_key_code", key_code, 4'hA);
        pressed = '0;
        wait_held(1'b0, DEB + 4, "two_row_release");
        tick(5);

        // Reset in the middle of debounce
        reset = 1'b0;
        pressed = '0;
        pressed[0] = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(8);
        reset = 1'b0;
        #1;
        check("mid_rst_cols", cols, 4'b1110);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_held", key_held, 1'b0);
        check("mid_rst_code", key_code, 4'h0);
        tick(1);
        pressed = '0;
        tick(1);
        reset = 1'b1;
        tick(LAT_MAX + DEB);
        check("post_rst_code", key_code, 4'h0);
        check("post_rst_held", key_held, 1'b0);

        // Long hold of key 0 (row3/col1): repeat pulses only when enabled
        exp_q.push_back(4'h0);
        pressed = '0;
        pressed[3*4+1] = 1'b1;
        wait_held(1'b1, LAT_MAX + 4, "long_hold_held");
        t_acc = last_pulse_cyc;
`ifdef KEYPAD_REPEAT_EN
        repeat (3) exp_q.push_back(4'h0);
        npulse = 4;
`else
        npulse = 1;
`endif
        tick(64);
        pressed = '0;
        wait_held(1'b0, DEB + 6, "long_hold_release");
        got.delete();
        foreach (pulse_cyc_q[i])
            if (pulse_cyc_q[i] >= t_acc) got.push_back(pulse_cyc_q[i] - t_acc);
        check("long_hold_pulses", got.size(), npulse);
        for (int k = 1; k < got.size(); k++)
            check("repeat_spacing", got[k], k * REP);
        tick(5);

        // Randomized presses, some with a short bounce first
        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(3, 0);
            c = $urandom_range(3, 0);
            if ($urandom_range(1, 0) == 1)
                press_release(r, c, $urandom_range(DEB - 2, 1), $urandom_range(3, 1),
                              $urandom_range(6, 0));
            else
                press_release(r, c, 0, 0, $urandom_range(6, 0));
            tick($urandom_range(10, 0));
        end

        tick(10);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
